// File: rtl/dcntr8_if.sv
// dcntr8 request/status bundle.
// Master drives load/dec/d_in, slave returns the count and flags.
interface dcntr8_if #(
   parameter int WIDTH = 8
);
   logic             load;
   logic             dec;
   logic [WIDTH-1:0] d_in;
   logic [WIDTH-1:0] d_out;
   logic [1:0]       o_state;
   logic             zero;
   logic             borrow;

   modport master (
      output load, dec, d_in,
      input  d_out, o_state, zero, borrow
   );

   modport slave (
      input  load, dec, d_in,
      output d_out, o_state, zero, borrow
   );
endinterface

// File: rtl/dcntr8.sv
// Loadable down-counter with a small IDLE/LOAD/DEC/HOLD FSM.
// Decrement adds all-ones through a chain of 4-bit CLA slices.
module cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // lookahead carries, flattened per bit
   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign c[2] = g[1] | (p[1] & g[0])
               | (p[1] & p[0] & ci);
   assign c[3] = g[2] | (p[2] & g[1])
               | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & ci);
   assign c[4] = g[3] | (p[3] & g[2])
               | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & ci);

   assign s  = p ^ c[3:0];
   assign co = c[4];
endmodule

module dcntr8 #(
   parameter int WIDTH = 8
) (
   input logic     clk,
   input logic     reset_n,
   dcntr8_if.slave bus
);
   localparam int NS = WIDTH / 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      LOAD = 2'b01,
      DEC  = 2'b10,
      HOLD = 2'b11
   } state_t;

   state_t           state;
   state_t           nxt;
   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_m1;
   logic [NS:0]      cy;
   logic             brw;

   assign cy[0] = 1'b0;

   for (genvar i = 0; i < NS; i++) begin : g_sl
      cla4 u_sl (
         .a  (cnt[4*i +: 4]),
         .b  (4'hF),
         .ci (cy[i]),
         .s  (cnt_m1[4*i +: 4]),
         .co (cy[i+1])
      );
   end

   // next state: load beats dec, idle only persists from idle
   always_comb begin
      nxt = HOLD;
      unique case (1'b1)
         bus.load:
            nxt = LOAD;
         (!bus.load && bus.dec):
            nxt = DEC;
         (!bus.load && !bus.dec):
            nxt = (state == IDLE) ? IDLE : HOLD;
      endcase
   end

   // state, count and borrow pulse registered together
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         brw   <= 1'b0;
      end else begin
         state <= nxt;
         brw   <= 1'b0;
         case (nxt)
            LOAD: cnt <= bus.d_in;
            DEC: begin
               cnt <= cnt_m1;
               // no carry out of x + all-ones means x was 0
               brw <= ~cy[NS];
            end
            default: cnt <= cnt;
         endcase
      end
   end

   assign bus.d_out   = cnt;
   assign bus.o_state = state;
   assign bus.zero    = (cnt == '0);
   assign bus.borrow  = brw;
endmodule

// File: tb/tb_dcntr8.sv
// Scoreboard bench for dcntr8.
// A behavioural model pushes expectations; results popped after each edge.
module tb_dcntr8;
   typedef struct packed {
      logic [7:0] d;
      logic [1:0] st;
      logic       z;
      logic       b;
   } exp_t;

   logic clk;
   logic reset_n;
   int   n_chk;
   int   n_fail;

   exp_t       sb[$];
   logic [7:0] m_cnt;
   logic [1:0] m_st;
   logic       m_b;

   dcntr8_if #(.WIDTH(8)) bus ();

   dcntr8 #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(
      input string tag,
      input int    obs,
      input int    exp
   );
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h",
                  tag, obs, exp);
      end
   endtask

   // drive one edge, model it, then compare
   task automatic step(
      input logic       rn,
      input logic       ld,
      input logic       dc,
      input logic [7:0] din,
      input string      tag
   );
      exp_t e;
      exp_t g;
      @(negedge clk);
      reset_n  = rn;
      bus.load = ld;
      bus.dec  = dc;
      bus.d_in = din;
      if (!rn) begin
         m_st  = 2'b00;
         m_cnt = 8'h00;
         m_b   = 1'b0;
      end else if (ld) begin
         m_st  = 2'b01;
         m_cnt = din;
         m_b   = 1'b0;
      end else if (dc) begin
         m_st  = 2'b10;
         m_b   = (m_cnt == 8'h00);
         m_cnt = m_cnt - 8'd1;
      end else begin
         m_st  = (m_st == 2'b00) ? 2'b00 : 2'b11;
         m_b   = 1'b0;
      end
      e.d  = m_cnt;
      e.st = m_st;
      e.z  = (m_cnt == 8'h00);
      e.b  = m_b;
      sb.push_back(e);
      @(posedge clk);
      #1;
      g = sb.pop_front();
      chk({tag, ".d_out"}, int'(bus.d_out), int'(g.d));
      chk({tag, ".state"}, int'(bus.o_state), int'(g.st));
      chk({tag, ".zero"}, int'(bus.zero), int'(g.z));
      chk({tag, ".borrow"}, int'(bus.borrow), int'(g.b));
   endtask

   initial begin
      n_chk    = 0;
      n_fail   = 0;
      reset_n  = 1'b0;
      bus.load = 1'b1;
      bus.dec  = 1'b1;
      bus.d_in = 8'h5A;

      // reset with both requests high
      step(1'b0, 1'b1, 1'b1, 8'h5A, "rst0");
      step(1'b0, 1'b1, 1'b1, 8'h5A, "rst1");
      chk("rst.dout_const", int'(bus.d_out), 0);

      // load 5, count to zero
      step(1'b1, 1'b1, 1'b0, 8'h05, "ld5");
      for (int i = 0; i < 5; i++)
         step(1'b1, 1'b0, 1'b1, 8'h00, "cd");
      chk("cd.zero_const", int'(bus.zero), 1);

      // wrap through zero
      step(1'b1, 1'b0, 1'b1, 8'h00, "wrap0");
      chk("wrap.ff_const", int'(bus.d_out), 8'hFF);
      step(1'b1, 1'b0, 1'b1, 8'h00, "wrap1");

      // load beats dec at zero
      step(1'b1, 1'b1, 1'b0, 8'h01, "pre");
      step(1'b1, 1'b0, 1'b1, 8'h00, "pre0");
      step(1'b1, 1'b1, 1'b1, 8'hA7, "prio");
      chk("prio.a7_const", int'(bus.d_out), 8'hA7);

      // hold at 3C
      step(1'b1, 1'b1, 1'b0, 8'h3D, "ld3d");
      step(1'b1, 1'b0, 1'b1, 8'h00, "to3c");
      for (int i = 0; i < 4; i++)
         step(1'b1, 1'b0, 1'b0, 8'h77, "hold");
      step(1'b1, 1'b0, 1'b1, 8'h00, "to3b");

      // reset in the middle of counting
      step(1'b1, 1'b1, 1'b0, 8'h80, "ld80");
      step(1'b1, 1'b0, 1'b1, 8'h00, "mid1");
      step(1'b1, 1'b0, 1'b1, 8'h00, "mid2");
      step(1'b0, 1'b0, 1'b1, 8'h00, "mid3");
      step(1'b1, 1'b0, 1'b1, 8'h00, "post");
      chk("post.borrow_const", int'(bus.borrow), 1);

      // random mix, dec-heavy to hit wraps
      for (int i = 0; i < 400; i++) begin
         logic       rn;
         logic       ld;
         logic       dc;
         logic [7:0] din;
         rn  = ($urandom_range(0, 40) != 0);
         ld  = ($urandom_range(0, 7) == 0);
         dc  = ($urandom_range(0, 3) != 0);
         din = 8'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1)
            din = 8'($urandom);
         step(rn, ld, dc, din, "rnd");
      end

      chk("sb.empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
